// File: rtl/rr_mux_arbiter_pkg.sv
// rr_mux_arbiter shared types and helpers.
// State encoding, requester indices, round-robin pick.
package rr_mux_arbiter_pkg;

  localparam int NUM_REQ = 4;

  localparam logic [1:0] REQ_A = 2'd0;
  localparam logic [1:0] REQ_B = 2'd1;
  localparam logic [1:0] REQ_C = 2'd2;
  localparam logic [1:0] REQ_D = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set request scanning ptr, ptr+1, ... (mod 4).
  function automatic logic [1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [1:0]         ptr
  );
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(
    input logic [1:0] s
  );
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter requester/sink bundle.
// slave: arbiter side; master: requesters and sink.
interface rr_mux_arbiter_if #(
  parameter int N = 4
);
  import rr_mux_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [N-1:0]       data_a;
  logic [N-1:0]       data_b;
  logic [N-1:0]       data_c;
  logic [N-1:0]       data_d;
  logic               out_ready;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         sel;
  logic               out_valid;
  logic [N-1:0]       out_data;
  logic               busy;

  modport slave (
    input  req, data_a, data_b, data_c, data_d,
    input  out_ready,
    output gnt, sel, out_valid, out_data, busy
  );

  modport master (
    output req, data_a, data_b, data_c, data_d,
    output out_ready,
    input  gnt, sel, out_valid, out_data, busy
  );

endinterface

// File: rtl/NBit_4x1_Multiplexer.sv
// N-bit 4-to-1 multiplexer.
// Select follows requester index order A..D.
module NBit_4x1_Multiplexer
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  input  logic [1:0]   s,
  output logic [N-1:0] y
);

  // Pure select, no storage.
  always_comb begin
    y = '0;
    case (s)
      REQ_A:   y = a;
      REQ_B:   y = b;
      REQ_C:   y = c;
      REQ_D:   y = d;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin burst arbiter over a shared 4x1 mux.
// Bursts capped at MAX_BURST beats, one idle bubble per grant.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 4
) (
  input logic            clk,
  input logic            rst,
  rr_mux_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST);

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld;
  logic          acc;
  logic [N-1:0]  mux_y;

  NBit_4x1_Multiplexer #(.N(N)) u_mux (
    .a (bus.data_a),
    .b (bus.data_b),
    .c (bus.data_c),
    .d (bus.data_d),
    .s (sel_q),
    .y (mux_y)
  );

  assign vld = (state_q == GRANT) & bus.req[sel_q];
  assign acc = vld & bus.out_ready;

  assign bus.gnt       = (state_q == GRANT) ? onehot(sel_q) : '0;
  assign bus.sel       = sel_q;
  assign bus.out_valid = vld;
  assign bus.out_data  = vld ? mux_y : '0;
  assign bus.busy      = (state_q == GRANT);

  // State register; reset overrides any in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbitration, burst counting and release.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          sel_d   = rr_pick(bus.req, ptr_q);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          state_d = IDLE;
          ptr_d   = sel_q + 2'd1;
        end else if (acc) begin
          if (cnt_q + CW'(1) == LAST) begin
            state_d = IDLE;
            ptr_d   = sel_q + 2'd1;
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// rr_mux_arbiter bench: beat scoreboard plus grant checks.
// Two DUTs: MAX_BURST=4 and MAX_BURST=1.
module tb_rr_mux_arbiter;
  import rr_mux_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] data;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req4 = '0;
  logic [3:0] req1 = '0;
  logic       rdy4 = 1'b0;
  logic       rdy1 = 1'b0;
  logic       adv  = 1'b0;
  logic [3:0] pend4 = '0;
  logic [3:0] pend1 = '0;
  logic [3:0] d4 [4];
  logic [3:0] d1 [4];
  logic [3:0] nx4 [4];
  logic [3:0] nx1 [4];
  beat_t      q4 [$];
  beat_t      q1 [$];
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.N(4)) bus4 ();
  rr_mux_arbiter_if #(.N(4)) bus1 ();

  assign bus4.req       = req4;
  assign bus4.data_a    = d4[0];
  assign bus4.data_b    = d4[1];
  assign bus4.data_c    = d4[2];
  assign bus4.data_d    = d4[3];
  assign bus4.out_ready = rdy4;
  assign bus1.req       = req1;
  assign bus1.data_a    = d1[0];
  assign bus1.data_b    = d1[1];
  assign bus1.data_c    = d1[2];
  assign bus1.data_d    = d1[3];
  assign bus1.out_ready = rdy1;

  rr_mux_arbiter #(.N(4), .MAX_BURST(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  rr_mux_arbiter #(.N(4), .MAX_BURST(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic observe();
    beat_t e;
    pend4 = '0;
    pend1 = '0;
    if (bus4.out_valid && rdy4 && !rst) begin
      chk("beat_expected4", 32'(q4.size() > 0), 32'd1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("beat_sel4", 32'(bus4.sel), 32'(e.id));
        chk("beat_data4", 32'(bus4.out_data), 32'(e.data));
      end
      pend4[bus4.sel] = adv;
    end
    if (bus1.out_valid && rdy1 && !rst) begin
      chk("beat_expected1", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("beat_sel1", 32'(bus1.sel), 32'(e.id));
        chk("beat_data1", 32'(bus1.out_data), 32'(e.data));
      end
      pend1[bus1.sel] = adv;
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pend4[i]) d4[i] = d4[i] + 4'd1;
      if (pend1[i]) d1[i] = d1[i] + 4'd1;
    end
  endtask

  task automatic push4(input logic [1:0] id, input int n);
    for (int k = 0; k < n; k++) begin
      q4.push_back(beat_t'{id: id, data: nx4[id]});
      nx4[id] = nx4[id] + 4'd1;
    end
  endtask

  task automatic push1(input logic [1:0] id, input int n);
    for (int k = 0; k < n; k++) begin
      q1.push_back(beat_t'{id: id, data: nx1[id]});
      nx1[id] = nx1[id] + 4'd1;
    end
  endtask

  task automatic set_base();
    for (int i = 0; i < 4; i++) begin
      d4[i]  = 4'(4 * i + 1);
      nx4[i] = 4'(4 * i + 1);
      d1[i]  = 4'(3 * i + 2);
      nx1[i] = 4'(3 * i + 2);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req4 = '0;
    req1 = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int ids [4];
    set_base();

    // reset state, with requests live during reset
    rst  = 1'b1;
    req4 = 4'hF;
    rdy4 = 1'b1;
    step();
    step();
    chk("rst_gnt", 32'(bus4.gnt), 32'h0);
    chk("rst_sel", 32'(bus4.sel), 32'h0);
    chk("rst_valid", 32'(bus4.out_valid), 32'h0);
    chk("rst_data", 32'(bus4.out_data), 32'h0);
    chk("rst_busy", 32'(bus4.busy), 32'h0);
    req4 = '0;
    rst  = 1'b0;
    step();

    // single requester A, constant data 5
    adv   = 1'b0;
    d4[0] = 4'h5;
    for (int k = 0; k < 4; k++)
      q4.push_back(beat_t'{id: REQ_A, data: 4'h5});
    req4 = 4'b0001;
    chk("t1_idle", 32'(bus4.gnt), 32'h0);
    step();
    chk("t1_gnt", 32'(bus4.gnt), 32'h1);
    chk("t1_busy", 32'(bus4.busy), 32'h1);
    repeat (4) step();
    chk("t1_bubble", 32'(bus4.gnt), 32'h0);
    step();
    chk("t1_regrant", 32'(bus4.gnt), 32'h1);
    req4 = '0;
    step();
    chk("t1_release", 32'(bus4.gnt), 32'h0);
    chk("t1_drain", 32'(q4.size()), 32'd0);

    // all four requesting: A,B,C,D,A, four beats each
    adv = 1'b1;
    set_base();
    do_reset();
    push4(REQ_A, 4);
    push4(REQ_B, 4);
    push4(REQ_C, 4);
    push4(REQ_D, 4);
    push4(REQ_A, 4);
    req4 = 4'b1111;
    chk("t2_idle", 32'(bus4.gnt), 32'h0);
    step();
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 4; b++) begin
        chk("t2_gnt", 32'(bus4.gnt), 32'(onehot(2'(g % 4))));
        step();
      end
      chk("t2_bubble", 32'(bus4.gnt), 32'h0);
      step();
    end
    req4 = '0;
    step();
    chk("t2_drain", 32'(q4.size()), 32'd0);

    // C granted with sink stalled for 3 cycles
    do_reset();
    rdy4 = 1'b0;
    req4 = 4'b0100;
    push4(REQ_C, 4);
    step();
    chk("t3_gnt", 32'(bus4.gnt), 32'h4);
    for (int k = 0; k < 3; k++) begin
      chk("t3_hold_valid", 32'(bus4.out_valid), 32'h1);
      chk("t3_hold_data", 32'(bus4.out_data), 32'(d4[2]));
      step();
    end
    rdy4 = 1'b1;
    chk("t3_still_gnt", 32'(bus4.gnt), 32'h4);
    repeat (4) step();
    chk("t3_release", 32'(bus4.gnt), 32'h0);
    req4 = '0;
    step();
    chk("t3_drain", 32'(q4.size()), 32'd0);

    // B drops after 2 beats; pending D beats A
    do_reset();
    req4 = 4'b0010;
    push4(REQ_B, 2);
    step();
    chk("t4_gnt", 32'(bus4.gnt), 32'h2);
    step();
    step();
    req4 = 4'b1001;
    step();
    chk("t4_release", 32'(bus4.gnt), 32'h0);
    step();
    chk("t4_d_wins", 32'(bus4.gnt), 32'h8);
    req4 = '0;
    step();
    chk("t4_drain", 32'(q4.size()), 32'd0);

    // reset mid-burst on C, then B must win from ptr 0
    req4 = 4'b0100;
    push4(REQ_C, 2);
    step();
    chk("t5_gnt", 32'(bus4.gnt), 32'h4);
    step();
    step();
    rst = 1'b1;
    step();
    chk("t5_gnt0", 32'(bus4.gnt), 32'h0);
    chk("t5_valid0", 32'(bus4.out_valid), 32'h0);
    chk("t5_data0", 32'(bus4.out_data), 32'h0);
    chk("t5_busy0", 32'(bus4.busy), 32'h0);
    chk("t5_sel0", 32'(bus4.sel), 32'h0);
    rst  = 1'b0;
    req4 = 4'b1010;
    step();
    chk("t5_b_wins", 32'(bus4.gnt), 32'h2);
    req4 = '0;
    step();
    chk("t5_drain", 32'(q4.size()), 32'd0);

    // MAX_BURST=1: B,C,B,C single beats with bubbles
    ids = '{1, 2, 1, 2};
    for (int k = 0; k < 4; k++) push1(2'(ids[k]), 1);
    rdy1 = 1'b1;
    req1 = 4'b0110;
    chk("t6_idle", 32'(bus1.gnt), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_gnt", 32'(bus1.gnt), 32'(onehot(2'(ids[k]))));
      step();
      chk("t6_bubble", 32'(bus1.gnt), 32'h0);
    end
    req1 = '0;
    step();
    chk("t6_drain", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one N-bit 4-to-1 multiplexer path between four requesters and forwards the granted requester's words to a single downstream sink under a valid/ready handshake. It sits in front of the N-bit 4x1 multiplexer and drives that multiplexer's select. Grants are held for bursts of up to MAX_BURST accepted beats, then rotated fairly.

## Interface
- N, default 4: data width of every requester and of the output.
- MAX_BURST, default 4: maximum accepted beats per grant (minimum 1).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  4  request per requester (bit i = requester i; A=0, B=1, C=2, D=3).
- data_a, data_b, data_c, data_d  in  N each  requester data; must stay stable while req[i] is high and the beat is not accepted.
- out_ready  in  1  sink can accept a beat this cycle.
- gnt  out  4  one-hot grant; all zero when idle.
- sel  out  2  multiplexer select of the current or most recent grant.
- out_valid  out  1  gnt[sel] & req[sel] while in GRANT.
- out_data  out  N  multiplexer output when out_valid, else all zero.
- busy  out  1  high in GRANT.

## Operation
- States: IDLE, GRANT. Registered: state, sel, ptr (2-bit next-priority index), beat count (width clog2(MAX_BURST+1)).
- IDLE: if any req bit set, winner = first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). Next cycle: state=GRANT, sel=winner, count=0. No request: stay IDLE.
- GRANT: gnt = one-hot(sel). A beat is accepted on a cycle with out_valid & out_ready; count increments.
- Release (-> IDLE, gnt cleared, ptr = sel+1 mod 4) when either:
  - req[sel] is low at a clock edge in GRANT (release without a beat on that cycle), or
  - an accepted beat brings count to MAX_BURST.
- A requester observes acceptance as gnt[i] & req[i] & out_ready; it advances its data on the following cycle.
- Requests of non-granted requesters are ignored during GRANT; they are not latched.
- Reset: state=IDLE, gnt=0, sel=0, ptr=0, count=0, out_valid=0, out_data=0, busy=0. Reset has priority over every other event, including mid-burst; the in-flight beat is not accepted.

## Timing
- Request-to-grant latency: req sampled high at edge k while IDLE -> gnt high from edge k+1.
- Each grant is followed by exactly one IDLE cycle (arbitration bubble); the bubble applies even when requests are pending.
- Throughput in GRANT: one beat per cycle while out_ready and req[sel] are high.
- out_valid and out_data are combinational from registered sel/state and live req/data; no combinational path from out_ready to out_valid.
- out_ready low: beat held, count unchanged, no timeout.
- req[sel] dropping on the same edge as the MAX_BURST beat: single release, ptr = sel+1.
- MAX_BURST=1: strict per-beat rotation, every beat separated by one IDLE cycle.
- ptr wraps 3 -> 0.

## Structure
- Shared package/header: state encodings (IDLE, GRANT), requester count 4, requester index constants A..D = 0..3.
- One sub-module: the existing NBit_4x1_Multiplexer, instantiated with parameter N, inputs data_a..data_d, select driven by sel; its output is gated to zero by out_valid.
- Round-robin scan, beat counter, and FSM stay in rr_mux_arbiter.

## Test plan
- Reset then req=4'b0001, data_a=4'h5, out_ready=1 held -> gnt=0001 one cycle after req, four beats of 4'h5 accepted, then gnt=0000 for one cycle, regrant A (ptr=1, only A requesting).
- req=4'b1111 held, out_ready=1, MAX_BURST=4 -> grant order A,B,C,D,A; each grant 4 beats, one idle cycle between grants.
- Grant to C, out_ready=0 for 3 cycles then 1 -> out_valid high, out_data=data_c, count stays 0 until ready, then 4 beats accepted.
- Grant to B, req[1] drops after 2 accepted beats -> release next edge, ptr=2; pending D (req=4'b1001) wins over A.
- rst asserted during GRANT after 2 beats -> next cycle gnt=0, out_valid=0, out_data=0, ptr=0; with req=4'b1010 afterwards, B wins.
- MAX_BURST=1, req=4'b0110 held -> alternating single beats B, C, B, C with one IDLE cycle between each.
